// File: rtl/cpu_dbg_pkg.sv
// Shared debug-controller types: FSM state encodings and the run divider default.
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_STEP  = 2'b01,
    ST_RUN   = 2'b10,
    ST_BREAK = 2'b11
  } dbg_state_e;

  localparam int unsigned RUN_DIV_DEF = 4;

  function automatic logic is_halted(dbg_state_e s);
    return (s == ST_HALT) || (s == ST_BREAK);
  endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Single-cycle rise detector; the delayed copy clears in reset so a level
// held through reset still counts as a rise on the first edge after release.
module rise_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic rise
);

  logic in_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in;
    end
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Step/run/breakpoint clock-enable controller for a teaching CPU.
// cpu_en is the sole gate on PC and register-file writes.
module cpu_step_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned RUN_DIV = RUN_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn,
  input  logic        run_sw,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc_now,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic        halted,
  output logic [31:0] cycle_count
);

  localparam logic [7:0] DIV_TC = 8'(RUN_DIV - 1);

  dbg_state_e  state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        en_q, en_d;
  logic        halted_q;
  logic [31:0] cnt_q;
  logic        rise;
  logic        tc;
  logic        bp_hit;

  rise_edge_detect u_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (btn),
    .rise  (rise)
  );

  assign tc     = (div_q == DIV_TC);
  assign bp_hit = bp_en && (pc_now == bp_addr);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    en_d    = 1'b0;
    unique case (state_q)
      ST_HALT: begin
        if (rise) begin
          div_d = 8'd0;
          if (run_sw) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_STEP;
            en_d    = 1'b1;
          end
        end
      end
      ST_STEP: begin
        state_d = ST_HALT;
      end
      ST_RUN: begin
        // Stop requests outrank the breakpoint, which outranks the pulse.
        if (!run_sw || rise) begin
          state_d = ST_HALT;
        end else if (tc && bp_hit) begin
          state_d = ST_BREAK;
        end else if (tc) begin
          en_d  = 1'b1;
          div_d = 8'd0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      ST_BREAK: begin
        if (rise) begin
          en_d    = 1'b1;
          div_d   = 8'd0;
          state_d = run_sw ? ST_RUN : ST_STEP;
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_HALT;
      div_q    <= 8'd0;
      en_q     <= 1'b0;
      halted_q <= 1'b1;
      cnt_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      en_q     <= en_d;
      halted_q <= is_halted(state_d);
      if (en_q) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign cpu_en      = en_q;
  assign state       = state_q;
  assign halted      = halted_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl; per-edge expectations go through a queue.
module tb_cpu_step_ctrl;

  localparam logic [1:0] H = 2'b00;
  localparam logic [1:0] S = 2'b01;
  localparam logic [1:0] R = 2'b10;
  localparam logic [1:0] B = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn;
  logic        run_sw;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc_now;
  logic        cpu_en;
  logic [1:0]  state;
  logic        halted;
  logic [31:0] cycle_count;

  typedef struct {
    string       tag;
    logic        en;
    logic [1:0]  st;
    logic        hl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic        pen;
  logic [31:0] ecnt;
  int          checks = 0;
  int          errors = 0;

  cpu_step_ctrl #(.RUN_DIV(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn         (btn),
    .run_sw      (run_sw),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .pc_now      (pc_now),
    .cpu_en      (cpu_en),
    .state       (state),
    .halted      (halted),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Count advances on each edge that sees the previous cycle's pulse.
  task automatic expect_edge(input string tag, input logic en,
                             input logic [1:0] st);
    exp_t e;
    ecnt  = ecnt + (pen ? 32'd1 : 32'd0);
    pen   = en;
    e.tag = tag;
    e.en  = en;
    e.st  = st;
    e.hl  = (st == H) || (st == B);
    e.cnt = ecnt;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty obs=0 exp=1");
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, ".en"}, {31'd0, cpu_en}, {31'd0, e.en});
      chk({e.tag, ".st"}, {30'd0, state}, {30'd0, e.st});
      chk({e.tag, ".hl"}, {31'd0, halted}, {31'd0, e.hl});
      chk({e.tag, ".cnt"}, cycle_count, e.cnt);
    end
  endtask

  task automatic step(input string tag, input logic en, input logic [1:0] st);
    expect_edge(tag, en, st);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    btn     = 1'b1;
    run_sw  = 1'b0;
    bp_en   = 1'b0;
    bp_addr = 32'h0;
    pc_now  = 32'h0;
    pen     = 1'b0;
    ecnt    = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.en", {31'd0, cpu_en}, 32'd0);
    chk("rst.st", {30'd0, state}, {30'd0, H});
    chk("rst.hl", {31'd0, halted}, 32'd1);
    chk("rst.cnt", cycle_count, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    step("held_rise", 1'b1, S);
    step("step_back", 1'b0, H);
    btn = 1'b0;
    step("halt_idle", 1'b0, H);
    step("halt_idle2", 1'b0, H);

    run_sw = 1'b1;
    btn    = 1'b1;
    step("run_enter", 1'b0, R);
    for (int k = 1; k <= 40; k++) begin
      if (k == 20) btn = 1'b0;
      step("run_div", (k % 4) == 0, R);
    end

    bp_en   = 1'b1;
    bp_addr = 32'h0000_001C;
    pc_now  = 32'h0000_001C;
    for (int k = 0; k < 3; k++) step("bp_wait", 1'b0, R);
    step("bp_hit", 1'b0, B);
    for (int k = 0; k < 3; k++) step("brk_hold", 1'b0, B);

    pc_now = 32'h0000_0020;
    btn    = 1'b1;
    step("brk_resume", 1'b1, R);
    btn = 1'b0;
    for (int k = 0; k < 3; k++) step("resume_gap", 1'b0, R);
    step("resume_pulse", 1'b1, R);
    for (int k = 0; k < 3; k++) step("prio_wait", 1'b0, R);
    btn    = 1'b1;
    pc_now = 32'h0000_001C;
    step("prio_rise", 1'b0, H);

    btn    = 1'b0;
    run_sw = 1'b0;
    step("halt_wait", 1'b0, H);
    btn = 1'b1;
    step("step_bp", 1'b1, S);
    step("step_bp_back", 1'b0, H);

    btn = 1'b0;
    step("halt_wait2", 1'b0, H);
    run_sw = 1'b1;
    btn    = 1'b1;
    pc_now = 32'h0000_0040;
    step("run2_enter", 1'b0, R);
    run_sw = 1'b0;
    step("sw_off", 1'b0, H);

    btn    = 1'b0;
    run_sw = 1'b1;
    step("halt_wait3", 1'b0, H);
    btn = 1'b1;
    step("run3_enter", 1'b0, R);
    btn    = 1'b0;
    pc_now = 32'h0000_001C;
    for (int k = 0; k < 3; k++) step("bp2_wait", 1'b0, R);
    step("bp2_hit", 1'b0, B);
    run_sw = 1'b0;
    btn    = 1'b1;
    step("brk_step", 1'b1, S);
    step("brk_step_back", 1'b0, H);

    btn    = 1'b0;
    run_sw = 1'b1;
    pc_now = 32'h0000_0040;
    step("halt_wait4", 1'b0, H);
    btn = 1'b1;
    step("run4_enter", 1'b0, R);
    for (int k = 0; k < 3; k++) step("run4_gap", 1'b0, R);
    step("pre_rst", 1'b1, R);

    rst_n = 1'b0;
    #1;
    chk("arst.en", {31'd0, cpu_en}, 32'd0);
    chk("arst.cnt", cycle_count, 32'd0);
    chk("arst.st", {30'd0, state}, {30'd0, H});
    chk("arst.hl", {31'd0, halted}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
